// File: rtl/mmc1_mapper.sv
// MMC1-class cartridge mapper: serial-loaded bank/control registers driving
// PRG-ROM, PRG-RAM, CHR and nametable (CIRAM) selects for the console buses.
module mmc1_mapper #(
  parameter int PRG_BANKS_LOG2 = 4,
  parameter int CHR_BANKS_LOG2 = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m2,
  input  logic                         rw,
  input  logic                         n_rom_sel,
  input  logic [14:0]                  cpu_addr,
  input  logic [7:0]                   cpu_data,
  input  logic [13:0]                  ppu_addr,
  output logic [PRG_BANKS_LOG2+13:0]   prg_addr,
  output logic                         prg_ce_n,
  output logic                         wram_ce_n,
  output logic [CHR_BANKS_LOG2+11:0]   chr_addr,
  output logic                         chr_ce_n,
  output logic                         n_vram_cs,
  output logic                         n_vram_a10
);

  typedef enum logic [1:0] {
    REG_CONTROL = 2'b00,
    REG_CHR0    = 2'b01,
    REG_CHR1    = 2'b10,
    REG_PRG     = 2'b11
  } reg_sel_e;

  typedef logic [PRG_BANKS_LOG2-1:0] prg_bank_t;
  typedef logic [CHR_BANKS_LOG2-1:0] chr_bank_t;

  // Bus capture taken while m2 is high, consumed on the m2 falling edge.
  logic     m2_q, m2_d;
  logic     cap_rw_q, cap_rw_d;
  logic     cap_rom_sel_n_q, cap_rom_sel_n_d;
  reg_sel_e cap_sel_q, cap_sel_d;
  logic     cap_d7_q, cap_d7_d;
  logic     cap_d0_q, cap_d0_d;

  logic       last_wr_q, last_wr_d;
  logic [4:0] shift_q, shift_d;
  logic [2:0] count_q, count_d;
  logic [4:0] control_q, control_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;

  logic       commit;
  logic       rom_wr;
  logic [4:0] shift_in;

  // Only the reset bit and the serial data bit carry meaning on the data bus.
  logic unused_data;
  assign unused_data = ^cpu_data[6:1];

  assign commit   = m2_q & ~m2;
  assign rom_wr   = ~cap_rw_q & ~cap_rom_sel_n_q;
  assign shift_in = {cap_d0_q, shift_q[4:1]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    m2_d            = m2;
    cap_rw_d        = cap_rw_q;
    cap_rom_sel_n_d = cap_rom_sel_n_q;
    cap_sel_d       = cap_sel_q;
    cap_d7_d        = cap_d7_q;
    cap_d0_d        = cap_d0_q;
    last_wr_d       = last_wr_q;
    shift_d         = shift_q;
    count_d         = count_q;
    control_d       = control_q;
    chr0_d          = chr0_q;
    chr1_d          = chr1_q;
    prg_d           = prg_q;

    if (m2) begin
      cap_rw_d        = rw;
      cap_rom_sel_n_d = n_rom_sel;
      cap_sel_d       = reg_sel_e'(cpu_addr[14:13]);
      cap_d7_d        = cpu_data[7];
      cap_d0_d        = cpu_data[0];
    end

    if (commit) begin
      last_wr_d = rom_wr;
      // A ROM write on the cycle right after another one is dropped entirely.
      if (rom_wr && !last_wr_q) begin
        if (cap_d7_q) begin
          shift_d        = '0;
          count_d        = '0;
          control_d[3:2] = 2'b11;
        end else if (count_q == 3'd4) begin
          shift_d = '0;
          count_d = '0;
          unique case (cap_sel_q)
            REG_CONTROL: control_d = shift_in;
            REG_CHR0:    chr0_d    = shift_in;
            REG_CHR1:    chr1_d    = shift_in;
            REG_PRG:     prg_d     = shift_in;
          endcase
        end else begin
          shift_d = shift_in;
          count_d = count_q + 3'd1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      m2_q            <= 1'b0;
      cap_rw_q        <= 1'b1;
      cap_rom_sel_n_q <= 1'b1;
      cap_sel_q       <= REG_CONTROL;
      cap_d7_q        <= 1'b0;
      cap_d0_q        <= 1'b0;
      last_wr_q       <= 1'b0;
      shift_q         <= '0;
      count_q         <= '0;
      control_q       <= 5'h0C;
      chr0_q          <= '0;
      chr1_q          <= '0;
      prg_q           <= '0;
    end else begin
      m2_q            <= m2_d;
      cap_rw_q        <= cap_rw_d;
      cap_rom_sel_n_q <= cap_rom_sel_n_d;
      cap_sel_q       <= cap_sel_d;
      cap_d7_q        <= cap_d7_d;
      cap_d0_q        <= cap_d0_d;
      last_wr_q       <= last_wr_d;
      shift_q         <= shift_d;
      count_q         <= count_d;
      control_q       <= control_d;
      chr0_q          <= chr0_d;
      chr1_q          <= chr1_d;
      prg_q           <= prg_d;
    end
  end

  prg_bank_t prg_bank;
  chr_bank_t chr_bank;

  always_comb begin
    prg_bank = '0;
    unique case (control_q[3:2])
      2'b00, 2'b01: prg_bank = prg_bank_t'({prg_q[3:1], cpu_addr[14]});
      2'b10:        prg_bank = cpu_addr[14] ? prg_bank_t'(prg_q[3:0]) : '0;
      2'b11:        prg_bank = cpu_addr[14] ? '1 : prg_bank_t'(prg_q[3:0]);
    endcase
  end

  always_comb begin
    chr_bank = '0;
    if (control_q[4]) chr_bank = chr_bank_t'(ppu_addr[12] ? chr1_q : chr0_q);
    else              chr_bank = chr_bank_t'({chr0_q[4:1], ppu_addr[12]});
  end

  always_comb begin
    n_vram_a10 = 1'b0;
    unique case (control_q[1:0])
      2'b00: n_vram_a10 = 1'b0;
      2'b01: n_vram_a10 = 1'b1;
      2'b10: n_vram_a10 = ppu_addr[10];
      2'b11: n_vram_a10 = ppu_addr[11];
    endcase
  end

  assign prg_addr  = {prg_bank, cpu_addr[13:0]};
  assign prg_ce_n  = n_rom_sel | ~rw;
  assign wram_ce_n = ~(m2 & n_rom_sel & (cpu_addr[14:13] == 2'b11) & ~prg_q[4]);
  assign chr_addr  = {chr_bank, ppu_addr[11:0]};
  assign chr_ce_n  = ppu_addr[13];
  assign n_vram_cs = ~ppu_addr[13];

endmodule

// File: tb/tb_mmc1_mapper.sv
// Directed bench for mmc1_mapper: serial loads, reset bit, back-to-back
// write filtering, PRG/CHR banking, mirroring and mid-sequence reset.
module tb_mmc1_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic        m2;
  logic        rw;
  logic        n_rom_sel;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic [13:0] ppu_addr;
  logic [17:0] prg_addr;
  logic        prg_ce_n;
  logic        wram_ce_n;
  logic [16:0] chr_addr;
  logic        chr_ce_n;
  logic        n_vram_cs;
  logic        n_vram_a10;

  int n_chk  = 0;
  int n_fail = 0;

  mmc1_mapper #(.PRG_BANKS_LOG2(4), .CHR_BANKS_LOG2(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .m2        (m2),
    .rw        (rw),
    .n_rom_sel (n_rom_sel),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .ppu_addr  (ppu_addr),
    .prg_addr  (prg_addr),
    .prg_ce_n  (prg_ce_n),
    .wram_ce_n (wram_ce_n),
    .chr_addr  (chr_addr),
    .chr_ce_n  (chr_ce_n),
    .n_vram_cs (n_vram_cs),
    .n_vram_a10(n_vram_a10)
  );

  always #5 clk = ~clk;

  // One CPU bus cycle: m2 high for two clocks, then low; returns after the commit edge.
  task automatic bus(input logic r, input logic sel_n, input logic [14:0] a, input logic [7:0] d);
    @(negedge clk);
    rw = r; n_rom_sel = sel_n; cpu_addr = a; cpu_data = d; m2 = 1'b1;
    repeat (2) @(negedge clk);
    m2 = 1'b0;
    @(negedge clk);
    rw = 1'b1; n_rom_sel = 1'b1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    bus(1'b0, 1'b0, a, d);
  endtask

  task automatic rd();
    bus(1'b1, 1'b0, 15'h0000, 8'h00);
  endtask

  task automatic load(input logic [14:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      wr(a, {7'b0, v[i]});
      rd();
    end
  endtask

  task automatic set_cpu(input logic [14:0] a);
    @(negedge clk);
    cpu_addr = a;
    #1;
  endtask

  task automatic set_ppu(input logic [13:0] a);
    @(negedge clk);
    ppu_addr = a;
    #1;
  endtask

  task automatic test_reset();
    set_cpu(15'h4123);
    n_chk++; if (prg_addr !== 18'h3C123) begin n_fail++; $display("FAIL reset_prg_hi: got %h exp %h", prg_addr, 18'h3C123); end
    set_cpu(15'h0123);
    n_chk++; if (prg_addr !== 18'h00123) begin n_fail++; $display("FAIL reset_prg_lo: got %h exp %h", prg_addr, 18'h00123); end
    rw = 1'b1; n_rom_sel = 1'b0; #1;
    n_chk++; if (prg_ce_n !== 1'b0) begin n_fail++; $display("FAIL prg_ce_read: got %b exp 0", prg_ce_n); end
    rw = 1'b0; #1;
    n_chk++; if (prg_ce_n !== 1'b1) begin n_fail++; $display("FAIL prg_ce_write: got %b exp 1", prg_ce_n); end
    rw = 1'b1; n_rom_sel = 1'b1; cpu_addr = 15'h6000; m2 = 1'b1; #1;
    n_chk++; if (wram_ce_n !== 1'b0) begin n_fail++; $display("FAIL wram_en_reset: got %b exp 0", wram_ce_n); end
    @(negedge clk); m2 = 1'b0; #1;
    n_chk++; if (wram_ce_n !== 1'b1) begin n_fail++; $display("FAIL wram_m2_low: got %b exp 1", wram_ce_n); end
    set_ppu(14'h1ABC);
    n_chk++; if (chr_addr !== 17'h01ABC) begin n_fail++; $display("FAIL reset_chr: got %h exp %h", chr_addr, 17'h01ABC); end
    set_ppu(14'h2400);
    n_chk++; if (n_vram_a10 !== 1'b0) begin n_fail++; $display("FAIL reset_a10: got %b exp 0", n_vram_a10); end
  endtask

  task automatic test_prg_load();
    logic [4:0] bits = 5'b00101;
    for (int i = 0; i < 4; i++) begin
      wr(15'h6000, {7'b0, bits[i]});
      rd();
    end
    @(negedge clk);
    rw = 1'b0; n_rom_sel = 1'b0; cpu_addr = 15'h6000; cpu_data = 8'h00; m2 = 1'b1;
    repeat (2) @(negedge clk);
    m2 = 1'b0; rw = 1'b1; n_rom_sel = 1'b1; cpu_addr = 15'h0010; #1;
    n_chk++; if (prg_addr !== 18'h00010) begin n_fail++; $display("FAIL prg_before_commit: got %h exp %h", prg_addr, 18'h00010); end
    @(negedge clk); #1;
    n_chk++; if (prg_addr !== 18'h14010) begin n_fail++; $display("FAIL prg_after_commit: got %h exp %h", prg_addr, 18'h14010); end
    rd();
  endtask

  task automatic test_wram();
    load(15'h6000, 5'h15);
    @(negedge clk);
    rw = 1'b1; n_rom_sel = 1'b1; cpu_addr = 15'h6000; m2 = 1'b1; #1;
    n_chk++; if (wram_ce_n !== 1'b1) begin n_fail++; $display("FAIL wram_disabled: got %b exp 1", wram_ce_n); end
    @(negedge clk); m2 = 1'b0;
    set_cpu(15'h0010);
    n_chk++; if (prg_addr !== 18'h14010) begin n_fail++; $display("FAIL prg_bit4_ignored: got %h exp %h", prg_addr, 18'h14010); end
    load(15'h6000, 5'h05);
  endtask

  task automatic test_reset_bit();
    load(15'h0000, 5'h00);
    set_cpu(15'h4123);
    n_chk++; if (prg_addr !== 18'h14123) begin n_fail++; $display("FAIL prg_32k_mode: got %h exp %h", prg_addr, 18'h14123); end
    wr(15'h0000, 8'h01); rd();
    wr(15'h0000, 8'h01); rd();
    wr(15'h0000, 8'h80); rd();
    set_cpu(15'h4123);
    n_chk++; if (prg_addr !== 18'h3C123) begin n_fail++; $display("FAIL reset_bit_mode3: got %h exp %h", prg_addr, 18'h3C123); end
    set_ppu(14'h2400);
    n_chk++; if (n_vram_a10 !== 1'b0) begin n_fail++; $display("FAIL reset_bit_mirror_kept: got %b exp 0", n_vram_a10); end
    load(15'h0000, 5'h08);
    set_cpu(15'h0123);
    n_chk++; if (prg_addr !== 18'h00123) begin n_fail++; $display("FAIL fresh_load_fixed0: got %h exp %h", prg_addr, 18'h00123); end
    set_cpu(15'h4123);
    n_chk++; if (prg_addr !== 18'h14123) begin n_fail++; $display("FAIL fresh_load_bank: got %h exp %h", prg_addr, 18'h14123); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rest = 4'b0001;
    wr(15'h6000, 8'h01);
    wr(15'h6000, 8'h01);
    rd();
    for (int i = 0; i < 4; i++) begin wr(15'h6000, {7'b0, rest[i]}); rd(); end
    set_cpu(15'h4123);
    n_chk++; if (prg_addr !== 18'h0C123) begin n_fail++; $display("FAIL b2b_shift_ignored: got %h exp %h", prg_addr, 18'h0C123); end
    rest = 4'b0100;
    wr(15'h6000, 8'h01);
    wr(15'h6000, 8'h80);
    rd();
    for (int i = 0; i < 4; i++) begin wr(15'h6000, {7'b0, rest[i]}); rd(); end
    set_cpu(15'h4123);
    n_chk++; if (prg_addr !== 18'h24123) begin n_fail++; $display("FAIL b2b_reset_ignored: got %h exp %h", prg_addr, 18'h24123); end
    set_cpu(15'h0123);
    n_chk++; if (prg_addr !== 18'h00123) begin n_fail++; $display("FAIL b2b_mode_kept: got %h exp %h", prg_addr, 18'h00123); end
  endtask

  task automatic test_m2_hold();
    logic [3:0] first = 4'b0110;
    for (int i = 0; i < 4; i++) begin wr(15'h6000, {7'b0, first[i]}); rd(); end
    @(negedge clk);
    rw = 1'b0; n_rom_sel = 1'b0; cpu_addr = 15'h6000; cpu_data = 8'h00; m2 = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    n_chk++; if (prg_addr !== 18'h26000) begin n_fail++; $display("FAIL m2_hold_no_commit: got %h exp %h", prg_addr, 18'h26000); end
    m2 = 1'b0; rw = 1'b1; n_rom_sel = 1'b1;
    @(negedge clk); #1;
    n_chk++; if (prg_addr !== 18'h1A000) begin n_fail++; $display("FAIL m2_release_commit: got %h exp %h", prg_addr, 18'h1A000); end
    rd();
  endtask

  task automatic test_mirroring();
    load(15'h0000, 5'h02);
    set_ppu(14'h2400);
    n_chk++; if (n_vram_a10 !== 1'b1) begin n_fail++; $display("FAIL vert_2400: got %b exp 1", n_vram_a10); end
    set_ppu(14'h2800);
    n_chk++; if (n_vram_a10 !== 1'b0) begin n_fail++; $display("FAIL vert_2800: got %b exp 0", n_vram_a10); end
    load(15'h0000, 5'h03);
    set_ppu(14'h2400);
    n_chk++; if (n_vram_a10 !== 1'b0) begin n_fail++; $display("FAIL horiz_2400: got %b exp 0", n_vram_a10); end
    set_ppu(14'h2800);
    n_chk++; if (n_vram_a10 !== 1'b1) begin n_fail++; $display("FAIL horiz_2800: got %b exp 1", n_vram_a10); end
    set_ppu(14'h2000);
    n_chk++; if (n_vram_cs !== 1'b0) begin n_fail++; $display("FAIL vram_cs_nt: got %b exp 0", n_vram_cs); end
    n_chk++; if (chr_ce_n !== 1'b1) begin n_fail++; $display("FAIL chr_ce_nt: got %b exp 1", chr_ce_n); end
    set_ppu(14'h0000);
    n_chk++; if (n_vram_cs !== 1'b1) begin n_fail++; $display("FAIL vram_cs_pat: got %b exp 1", n_vram_cs); end
    n_chk++; if (chr_ce_n !== 1'b0) begin n_fail++; $display("FAIL chr_ce_pat: got %b exp 0", chr_ce_n); end
    load(15'h0000, 5'h01);
    set_ppu(14'h2000);
    n_chk++; if (n_vram_a10 !== 1'b1) begin n_fail++; $display("FAIL single_upper: got %b exp 1", n_vram_a10); end
  endtask

  task automatic test_chr();
    load(15'h0000, 5'h10);
    load(15'h2000, 5'h03);
    load(15'h4000, 5'h07);
    set_ppu(14'h0ABC);
    n_chk++; if (chr_addr !== 17'h03ABC) begin n_fail++; $display("FAIL chr4k_lo: got %h exp %h", chr_addr, 17'h03ABC); end
    set_ppu(14'h1ABC);
    n_chk++; if (chr_addr !== 17'h07ABC) begin n_fail++; $display("FAIL chr4k_hi: got %h exp %h", chr_addr, 17'h07ABC); end
    load(15'h0000, 5'h00);
    set_ppu(14'h0ABC);
    n_chk++; if (chr_addr !== 17'h02ABC) begin n_fail++; $display("FAIL chr8k_lo: got %h exp %h", chr_addr, 17'h02ABC); end
    set_ppu(14'h1ABC);
    n_chk++; if (chr_addr !== 17'h03ABC) begin n_fail++; $display("FAIL chr8k_hi: got %h exp %h", chr_addr, 17'h03ABC); end
  endtask

  task automatic test_reset_mid();
    load(15'h0000, 5'h13);
    for (int i = 0; i < 3; i++) begin wr(15'h6000, 8'h01); rd(); end
    @(negedge clk);
    rw = 1'b0; n_rom_sel = 1'b0; cpu_addr = 15'h6000; cpu_data = 8'h01; m2 = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; m2 = 1'b0; rw = 1'b1; n_rom_sel = 1'b1;
    set_cpu(15'h4123);
    n_chk++; if (prg_addr !== 18'h3C123) begin n_fail++; $display("FAIL midreset_prg_hi: got %h exp %h", prg_addr, 18'h3C123); end
    set_cpu(15'h0123);
    n_chk++; if (prg_addr !== 18'h00123) begin n_fail++; $display("FAIL midreset_prg_lo: got %h exp %h", prg_addr, 18'h00123); end
    set_ppu(14'h1ABC);
    n_chk++; if (chr_addr !== 17'h01ABC) begin n_fail++; $display("FAIL midreset_chr: got %h exp %h", chr_addr, 17'h01ABC); end
    set_ppu(14'h2800);
    n_chk++; if (n_vram_a10 !== 1'b0) begin n_fail++; $display("FAIL midreset_mirror: got %b exp 0", n_vram_a10); end
    load(15'h6000, 5'h05);
    set_cpu(15'h0010);
    n_chk++; if (prg_addr !== 18'h14010) begin n_fail++; $display("FAIL midreset_no_stale: got %h exp %h", prg_addr, 18'h14010); end
  endtask

  initial begin
    reset = 1'b1; m2 = 1'b0; rw = 1'b1; n_rom_sel = 1'b1;
    cpu_addr = '0; cpu_data = '0; ppu_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_prg_load();
    test_wram();
    test_reset_bit();
    test_back_to_back();
    test_m2_hold();
    test_mirroring();
    test_chr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmc1_mapper.md
Name: mmc1_mapper

Overview:
- Cartridge-side responder for the console's CPU and PPU cartridge buses: MMC1-class bank-switching mapper.
- Decodes CPU writes to $8000-$FFFF through a 5-bit serial load port and holds four bank/control registers.
- Drives PRG-ROM, CHR and PRG-RAM addresses and enables, plus nametable CIRAM select and A10 mirroring back to the console.

Parameters:
PRG_BANKS_LOG2, 4, log2 of the number of 16 KB PRG banks (prg_addr width = PRG_BANKS_LOG2+14)
CHR_BANKS_LOG2, 5, log2 of the number of 4 KB CHR banks (chr_addr width = CHR_BANKS_LOG2+12)

Ports:
clk  input  1  system clock; the only clock, much faster than m2
reset  input  1  synchronous, active-high reset
m2  input  1  CPU M2 phase from console
rw  input  1  CPU read(1)/write(0)
n_rom_sel  input  1  low = CPU access to $8000-$FFFF
cpu_addr  input  15  CPU A14..A0
cpu_data  input  8  CPU data bus (mapper samples only, never drives)
ppu_addr  input  14  PPU address as driven by console; bit 13 high = nametable region
prg_addr  output  PRG_BANKS_LOG2+14  PRG-ROM address
prg_ce_n  output  1  PRG-ROM chip enable = n_rom_sel | ~rw
wram_ce_n  output  1  PRG-RAM ($6000-$7FFF) chip enable
chr_addr  output  CHR_BANKS_LOG2+12  CHR address
chr_ce_n  output  1  CHR enable = ppu_addr[13]
n_vram_cs  output  1  CIRAM select = ~ppu_addr[13]
n_vram_a10  output  1  CIRAM A10 per mirroring

Behaviour:
- One clock domain, clk; reset is synchronous and active-high. Reset overrides everything, including mid-sequence serial loads and an active m2.
- Reset values:
  - control=5'h0C, chr0=0, chr1=0, prg=0 (prg[4]=0, i.e. RAM enabled).
  - shift=0, count=0, last_wr=0.
- All outputs are combinational from registers and current inputs; they are valid the clk after reset is released.
- Bus capture:
  - On every clk with m2=1, register rw, n_rom_sel, cpu_addr[14:13] and cpu_data.
  - Commit on the first clk with m2=0 whose previous sample was m2=1 (M2 falling edge), using the captured values.
- ROM write = captured rw=0 and n_rom_sel=0. At each commit, last_wr <= ROM write.
- Consecutive-cycle rule: a ROM write committed while last_wr=1 is ignored entirely (no shift, no reset-bit action).
- Accepted write with d[7]=1: shift=0, count=0, control[3:2]=2'b11. Other control bits are unchanged.
- Accepted write with d[7]=0: shift = {d[0], shift[4:1]}, count+1.
  - On the 5th bit (count==4), the full 5-bit value {d[0], shift[4:1]} goes to the register selected by captured addr[14:13]: 00 control, 01 chr0, 10 chr1, 11 prg.
  - Then shift=0 and count=0.
- Register update latency: visible on outputs 1 clk after the commit clk.
- PRG mapping (control[3:2], CPU offset cpu_addr[13:0]):
  - 0/1: 32 KB bank, prg_addr = {prg[3:1], cpu_addr[14:0]}.
  - 2: $8000 fixed to bank 0, $C000 uses prg[3:0].
  - 3: $8000 uses prg[3:0], $C000 fixed to the last bank (all ones).
  - Bank fields are truncated or zero-extended to PRG_BANKS_LOG2.
- wram_ce_n = 0 only when m2=1, n_rom_sel=1, cpu_addr[14:13]=2'b11 and prg[4]=0.
- CHR mapping:
  - control[4]=0 (8 KB): chr_addr = {chr0[4:1], ppu_addr[12:0]}.
  - control[4]=1 (4 KB): ppu_addr[12]=0 uses chr0, else chr1, with offset ppu_addr[11:0].
- Mirroring (control[1:0]): 0 -> A10=0; 1 -> A10=1; 2 (vertical) -> ppu_addr[10]; 3 (horizontal) -> ppu_addr[11].
- m2 held high indefinitely: no commit occurs. Reads ($8000+, rw=1) never change state but do clear last_wr.

Test Plan:
- Reset, no writes -> cpu_addr 0x4123 gives prg_addr 0x3C123; cpu_addr 0x0123 gives 0x00123; prg_ce_n=0 when rw=1 and n_rom_sel=0.
- Five ROM writes to cpu_addr 0x6000 with d[0]=1,0,1,0,0, each separated by a read cycle -> prg=5; cpu_addr 0x0010 gives prg_addr 0x14010, visible 1 clk after the 5th commit.
- Two serial bits written, then d=0x80 -> count=0 and control[3:2]=11; five fresh bits then load correctly, with no stale bits.
- ROM writes on back-to-back M2 cycles (d=0x01 then d=0x01) -> only the first shifts (count=1). A reset-bit write on the second cycle is also ignored.
- Control=0x02: ppu_addr 0x2400 gives n_vram_a10=1, 0x2800 gives 0. Control=0x03: 0x2400 gives 0, 0x2800 gives 1. n_vram_cs=0 at 0x2000, 1 at 0x0000.
- Control=0x10, chr0=3, chr1=7: ppu 0x0ABC gives chr_addr 0x03ABC; 0x1ABC gives 0x07ABC. Control=0x00, chr0=3: 0x0ABC gives 0x02ABC; 0x1ABC gives 0x03ABC. Reset asserted mid-sequence (count=3) -> all registers return to reset values.
